// File: rtl/data_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter_pkg
// Description : Shared state encoding, requester indices and helpers for the
//               data memory arbiter.
// Revision    : 1.0
// ============================================================================
package data_mem_arbiter_pkg;

   localparam logic [0:0] c_IDLE   = 1'b0;
   localparam logic [0:0] c_ACCESS = 1'b1;

   localparam logic [0:0] c_REQ0 = 1'b0;
   localparam logic [0:0] c_REQ1 = 1'b1;

   // Word accesses only: the two low address bits must be zero.
   function automatic logic isAligned(input logic [1:0] lowBits);
      return (lowBits == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way round-robin pick; Last names the most recent winner.
// Revision    : 1.0
// ============================================================================
module rr_pick2
   import data_mem_arbiter_pkg::*;
(
   input  logic       Req0,
   input  logic       Req1,
   input  logic       Last,
   output logic [1:0] Gnt
);

   always_comb begin
      Gnt = 2'b00;
      if (Req0 && Req1) begin
         // Conflict goes to whoever did not win most recently.
         if (Last == c_REQ1) Gnt = 2'b01;
         else                Gnt = 2'b10;
      end else if (Req0) begin
         Gnt = 2'b01;
      end else if (Req1) begin
         Gnt = 2'b10;
      end
   end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_arbiter
// Description : Two-requester single-port data memory arbiter, one command
//               accepted per cycle, completion two cycles after grant.
// Revision    : 1.0
// ============================================================================
module data_mem_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Req0,
   input  logic          We0,
   input  logic [AW-1:0] Addr0,
   input  logic [DW-1:0] WData0,
   input  logic          Req1,
   input  logic          We1,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] WData1,
   output logic          Gnt0,
   output logic          Gnt1,
   output logic          RValid0,
   output logic [DW-1:0] RData0,
   output logic          Err0,
   output logic          RValid1,
   output logic [DW-1:0] RData1,
   output logic          Err1,
   output logic [AW-1:0] MemAddress,
   output logic [DW-1:0] MemWriteData,
   output logic          MemWrite,
   output logic          MemRead,
   input  logic [DW-1:0] MemReadData
);

   import data_mem_arbiter_pkg::*;

   logic [1:0]    w_gnt;
   logic          w_accept;
   logic [0:0]    w_gntIdx;
   logic [0:0]    w_nextState;
   logic          w_aligned;
   logic          w_done0;
   logic          w_done1;
   logic          w_readOk;

   logic [0:0]    r_state;
   logic [0:0]    r_last;
   logic [0:0]    r_owner;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;

   rr_pick2 u_pick (
      .Req0 (Req0),
      .Req1 (Req1),
      .Last (r_last),
      .Gnt  (w_gnt)
   );

   assign Gnt0     = w_gnt[0];
   assign Gnt1     = w_gnt[1];
   assign w_accept = |w_gnt;
   assign w_gntIdx = w_gnt[1] ? c_REQ1 : c_REQ0;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= c_IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = c_IDLE;
      if (w_accept) w_nextState = c_ACCESS;
   end

   // Winner's command is captured so the requester is free next cycle.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_last  <= c_REQ1;
         r_owner <= c_REQ0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_accept) begin
         r_last  <= w_gntIdx;
         r_owner <= w_gntIdx;
         r_we    <= w_gnt[1] ? We1    : We0;
         r_addr  <= w_gnt[1] ? Addr1  : Addr0;
         r_wdata <= w_gnt[1] ? WData1 : WData0;
      end
   end

   assign w_aligned = isAligned(r_addr[1:0]);

   always_comb begin
      MemAddress   = '0;
      MemWriteData = '0;
      MemWrite     = 1'b0;
      MemRead      = 1'b0;
      if (r_state == c_ACCESS) begin
         MemAddress   = r_addr;
         MemWriteData = r_wdata;
         MemWrite     = r_we && w_aligned;
         MemRead      = !r_we && w_aligned;
      end
   end

   assign w_done0  = (r_state == c_ACCESS) && (r_owner == c_REQ0);
   assign w_done1  = (r_state == c_ACCESS) && (r_owner == c_REQ1);
   assign w_readOk = !r_we && w_aligned;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         RValid0 <= 1'b0;
         RData0  <= '0;
         Err0    <= 1'b0;
         RValid1 <= 1'b0;
         RData1  <= '0;
         Err1    <= 1'b0;
      end else begin
         RValid0 <= w_done0;
         RData0  <= (w_done0 && w_readOk) ? MemReadData : '0;
         Err0    <= w_done0 && !w_aligned;
         RValid1 <= w_done1;
         RData1  <= (w_done1 && w_readOk) ? MemReadData : '0;
         Err1    <= w_done1 && !w_aligned;
      end
   end

endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Req0 / Req1  input  1  request from requester 0 (CPU MEM stage) / requester 1 (loader/debug port).
REQ-006 We0 / We1  input  1  1 = write, 0 = read, qualified by ReqN.
REQ-007 Addr0 / Addr1  input  AW  byte address, qualified by ReqN.
REQ-008 WData0 / WData1  input  DW  write data, qualified by ReqN and WeN.
REQ-009 Gnt0 / Gnt1  output  1  combinational accept; command captured at this rising edge.
REQ-010 RValid0 / RValid1  output  1  one-cycle pulse marking completion of the accepted command.
REQ-011 RData0 / RData1  output  DW  read data, valid while RValidN is high.
REQ-012 Err0 / Err1  output  1  misaligned-access flag, valid while RValidN is high.
REQ-013 MemAddress  output  AW  address to the data memory.
REQ-014 MemWriteData  output  DW  write data to the data memory.
REQ-015 MemWrite / MemRead  output  1  data memory strobes, mutually exclusive.
REQ-016 MemReadData  input  DW  combinational read data from the data memory.

Function
REQ-017 States: IDLE (no captured command) and ACCESS (one captured command driving memory this cycle).
REQ-018 A request is accepted every cycle in which any ReqN is high, giving one-per-cycle throughput.
REQ-019 Transitions: IDLE or ACCESS goes to ACCESS when a command is accepted; otherwise to IDLE.
REQ-020 At most one GntN is high per cycle; GntN is never high without ReqN.
REQ-021 Only one requester high: that requester is granted.
REQ-022 Both requesters high: the one not granted most recently wins (round-robin, 1-bit pointer Last).
REQ-023 Last updates to the granted index on every grant and holds otherwise.
REQ-024 On grant, the command (owner, We, Addr, WData) is registered; the requester may change or drop it next cycle.
REQ-025 Ungranted requesters hold Req and the command stable until granted; the block does not store them.
REQ-026 In ACCESS, MemAddress and MemWriteData come from the captured command.
REQ-027 In ACCESS, MemWrite = We and MemRead = !We when captured Addr[1:0] == 0.
REQ-028 In ACCESS with captured Addr[1:0] != 0, both memory strobes stay 0.
REQ-029 Latency: grant at edge N; memory access in cycle N+1; RValid/RData/Err of the owner registered at edge N+1 and visible in cycle N+2.
REQ-030 RDataN = MemReadData sampled in the access cycle for reads; 0 for writes and misaligned accesses.
REQ-031 ErrN = 1 exactly when the completed command was misaligned.
REQ-032 Only the owner's RValid pulses; the other requester's RValid, RData and Err stay 0.
REQ-033 MemAddress and MemWriteData are 0 in IDLE.

Reset
REQ-034 Reset forces IDLE, sets Last = 1 (requester 0 wins the first conflict), and clears the captured command.
REQ-035 Reset forces all RValid, RData, Err, MemWrite and MemRead to 0 immediately, without waiting for Clk.
REQ-036 A command in flight during reset is discarded: no memory strobe and no RValid after reset deasserts.

Structure
REQ-037 Shared package holds the state encoding (IDLE = 0, ACCESS = 1) and the requester index constants.
REQ-038 The round-robin pick (two requests plus Last in; grant vector out) is a separate combinational sub-module, rr_pick2.

Verification
REQ-039 Req0 read Addr=0x10 alone, memory returns 0xDEADBEEF -> Gnt0 at edge N, MemRead=1 with MemAddress=0x10 in N+1, RValid0=1 with RData0=0xDEADBEEF in N+2.
REQ-040 Req0 and Req1 held high for 4 cycles after reset -> grants in order 0, 1, 0, 1, with exactly one Gnt per cycle.
REQ-041 Req1 write Addr=0x20 WData=0x12345678 -> MemWrite=1, MemAddress=0x20, MemWriteData=0x12345678 for one cycle; RValid1=1, RData1=0, Err1=0.
REQ-042 Req0 read Addr=0x13 -> no MemRead or MemWrite; RValid0=1, Err0=1, RData0=0.
REQ-043 Back-to-back Req0 writes to 0x0, 0x4, 0x8 -> memory strobes on 3 consecutive cycles; 3 consecutive RValid0 pulses.
REQ-044 Reset asserted mid-cycle during ACCESS -> MemWrite, MemRead and RValid drop to 0 without waiting for Clk; no completion after release.
